// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle for the 16-bit multi-cycle CPU.
//
// master : the control unit. It samples Opcode/Zero/MemReady and drives every
//          datapath enable, the ALUOp code, the status flags and InstrCount.
// slave  : the datapath/memory side. It drives Opcode/Zero/MemReady and
//          consumes the controls.
//
// Signals
//   Opcode[3:0]      instruction[15:12] from the instruction register
//   Zero             ALU zero flag (the datapath ANDs it with PCWriteCond)
//   MemReady         memory completes the current read/write this cycle
//   PCWrite          unconditional PC load
//   PCWriteCond      PC load qualified by Zero
//   IorD             0 = PC addresses memory, 1 = ALUOut addresses memory
//   MemRead/MemWrite memory requests (never both high)
//   IRWrite          instruction register load
//   MemToReg         1 = write back from MDR, 0 = from ALUOut
//   RegDst           1 = rd, 0 = rt
//   RegWrite         register file write enable
//   ALUSrcA          0 = PC, 1 = register A
//   ALUSrcB[1:0]     00 = B, 01 = const 2, 10 = sign-ext imm, 11 = imm << 1
//   ALUOp[1:0]       00 = add, 01 = sub, 10 = decode by Funct
//   PCSource[1:0]    00 = ALU result, 01 = ALUOut, 10 = jump target
//   IllegalOp        one-cycle pulse in DECODE on an unknown opcode
//   Halted           high while parked in HALT
//   InstrCount       retired-instruction counter, wraps to 0
interface multicycle_control_unit_if #(
  parameter int unsigned COUNT_WIDTH = 16
);
  logic [3:0]             Opcode;
  logic                   Zero;
  logic                   MemReady;
  logic                   PCWrite;
  logic                   PCWriteCond;
  logic                   IorD;
  logic                   MemRead;
  logic                   MemWrite;
  logic                   IRWrite;
  logic                   MemToReg;
  logic                   RegDst;
  logic                   RegWrite;
  logic                   ALUSrcA;
  logic [1:0]             ALUSrcB;
  logic [1:0]             ALUOp;
  logic [1:0]             PCSource;
  logic                   IllegalOp;
  logic                   Halted;
  logic [COUNT_WIDTH-1:0] InstrCount;

  modport master (
    input  Opcode, Zero, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp, Halted, InstrCount
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp, Halted, InstrCount
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Main multi-cycle control FSM of the 16-bit CPU.
//
// Sequences FETCH / DECODE / EXECUTE / MEM / WRITEBACK, decodes the opcode
// latched in the instruction register, drives every datapath enable and
// produces ALUOp for the downstream ALU control decoder. Also counts retired
// instructions.
//
// Ports
//   Clock  rising-edge clock, single domain
//   Reset  synchronous, active-high; forces every output to 0 in its cycle
//   bus    control bundle (master side), see multicycle_control_unit_if
//
// Parameters
//   COUNT_WIDTH  width of InstrCount (must match the interface instance)
//   HALT_OPCODE  opcode that parks the FSM in HALT until Reset
//
// Output timing: the Moore controls are registered from the next state so they
// line up with the state register. IRWrite/PCWrite in FETCH follow MemReady in
// the same cycle, and IllegalOp follows Opcode in DECODE, so those stay
// combinational.
module multicycle_control_unit #(
  parameter int unsigned COUNT_WIDTH = 16,
  parameter logic [3:0]  HALT_OPCODE = 4'b1111
) (
  input logic                       Clock,
  input logic                       Reset,
  multicycle_control_unit_if.master bus
);

  localparam logic [3:0] OpRType = 4'b0000;
  localparam logic [3:0] OpAddi  = 4'b0001;
  localparam logic [3:0] OpLw    = 4'b0010;
  localparam logic [3:0] OpSw    = 4'b0011;
  localparam logic [3:0] OpBeq   = 4'b0100;
  localparam logic [3:0] OpJ     = 4'b0101;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StExecR,
    StWbR,
    StExecI,
    StWbI,
    StMemAddr,
    StMemRead,
    StWbMem,
    StMemWrite,
    StBranch,
    StJump,
    StHalt
  } state_e;

  // Registered Moore controls. IRWrite is absent: it only exists in FETCH and
  // depends on MemReady, so it is built at the output.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

  // Moore decode of a state; anything not set stays 0.
  function automatic ctrl_t ctrl_of(state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      StFetch: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      StDecode: begin
        c.alu_src_b = 2'b11;
      end
      StExecR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b00;
        c.alu_op    = 2'b10;
      end
      StWbR: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      StExecI, StMemAddr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      StWbI: begin
        c.reg_write = 1'b1;
      end
      StMemRead: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      StWbMem: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      StMemWrite: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      StBranch: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      StJump: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      StHalt: begin
        c.halted = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  state_e                 state_q, state_d;
  logic                   is_lw_q, is_lw_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  ctrl_t                  ctrl_q, ctrl_d;
  ctrl_t                  ctrl_out;
  logic                   retire;
  logic                   opcode_legal;
  logic                   fetch_ready;

  always_comb begin
    opcode_legal = (bus.Opcode == HALT_OPCODE) || (bus.Opcode == OpRType) ||
                   (bus.Opcode == OpAddi) || (bus.Opcode == OpLw) || (bus.Opcode == OpSw) ||
                   (bus.Opcode == OpBeq) || (bus.Opcode == OpJ);
  end

  // Next state. Opcode is only looked at in DECODE; MEM_ADDR needs to remember
  // lw vs sw, hence is_lw.
  always_comb begin
    state_d = state_q;
    is_lw_d = is_lw_q;
    case (state_q)
      StFetch: begin
        if (bus.MemReady) state_d = StDecode;
      end
      StDecode: begin
        is_lw_d = (bus.Opcode == OpLw);
        if (bus.Opcode == HALT_OPCODE) begin
          state_d = StHalt;
        end else begin
          case (bus.Opcode)
            OpRType:     state_d = StExecR;
            OpAddi:      state_d = StExecI;
            OpLw, OpSw:  state_d = StMemAddr;
            OpBeq:       state_d = StBranch;
            OpJ:         state_d = StJump;
            default:     state_d = StFetch;
          endcase
        end
      end
      StExecR:    state_d = StWbR;
      StWbR:      state_d = StFetch;
      StExecI:    state_d = StWbI;
      StWbI:      state_d = StFetch;
      StMemAddr:  state_d = is_lw_q ? StMemRead : StMemWrite;
      StMemRead: begin
        if (bus.MemReady) state_d = StWbMem;
      end
      StWbMem:    state_d = StFetch;
      StMemWrite: begin
        if (bus.MemReady) state_d = StFetch;
      end
      StBranch:   state_d = StFetch;
      StJump:     state_d = StFetch;
      StHalt:     state_d = StHalt;
      default:    state_d = StFetch;
    endcase
  end

  // An instruction retires on its last state's hand-back to FETCH. DECODE ->
  // FETCH (illegal opcode) is deliberately not in the list.
  always_comb begin
    retire = 1'b0;
    if (state_d == StFetch) begin
      case (state_q)
        StWbR, StWbI, StWbMem, StMemWrite, StBranch, StJump: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  always_comb begin
    count_d = retire ? count_q + COUNT_WIDTH'(1) : count_q;
    ctrl_d  = ctrl_of(state_d);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StFetch;
      is_lw_q <= 1'b0;
      count_q <= '0;
      ctrl_q  <= ctrl_of(StFetch);
    end else begin
      state_q <= state_d;
      is_lw_q <= is_lw_d;
      count_q <= count_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Everything is held at 0 while Reset is high, which also drops any memory
  // request of an aborted instruction in that same cycle.
  always_comb begin
    ctrl_out    = Reset ? ctrl_t'('0) : ctrl_q;
    fetch_ready = !Reset && (state_q == StFetch) && bus.MemReady;
  end

  assign bus.PCWrite     = ctrl_out.pc_write | fetch_ready;
  assign bus.IRWrite     = fetch_ready;
  assign bus.PCWriteCond = ctrl_out.pc_write_cond;
  assign bus.IorD        = ctrl_out.iord;
  assign bus.MemRead     = ctrl_out.mem_read;
  assign bus.MemWrite    = ctrl_out.mem_write;
  assign bus.MemToReg    = ctrl_out.mem_to_reg;
  assign bus.RegDst      = ctrl_out.reg_dst;
  assign bus.RegWrite    = ctrl_out.reg_write;
  assign bus.ALUSrcA     = ctrl_out.alu_src_a;
  assign bus.ALUSrcB     = ctrl_out.alu_src_b;
  assign bus.ALUOp       = ctrl_out.alu_op;
  assign bus.PCSource    = ctrl_out.pc_source;
  assign bus.Halted      = ctrl_out.halted;
  assign bus.IllegalOp   = !Reset && (state_q == StDecode) && !opcode_legal;
  assign bus.InstrCount  = Reset ? '0 : count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit. A small instruction-level model holds the
// list of steps still to run for the current instruction (built from the
// opcode when DECODE is reached) plus a retired count; every cycle the DUT
// outputs and InstrCount are compared with what the current step demands.
// Directed sequences add literal expectations on top.
module tb_multicycle_control_unit;
  // Narrow counter so the wrap-around is reachable with real instructions.
  localparam int unsigned CW = 8;

  localparam int P_FETCH = 0, P_DECODE = 1, P_EXR = 2, P_WBR = 3, P_EXI = 4, P_WBI = 5;
  localparam int P_MADDR = 6, P_MRD = 7, P_WBM = 8, P_MWR = 9, P_BR = 10, P_J = 11;
  localparam int P_HALT = 12;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       halted;
  } ov_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.COUNT_WIDTH(CW)) bus ();

  multicycle_control_unit #(
    .COUNT_WIDTH(CW),
    .HALT_OPCODE(4'b1111)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Model state.
  int          q[$];
  bit          retiring;
  bit          instr_end;
  int unsigned m_count;

  // Last sampled DUT values.
  ov_t sv;
  int  sc;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic chk_vec(string name, ov_t act, ov_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic ov_t dut_vec();
    ov_t v;
    v.pc_write      = bus.PCWrite;
    v.pc_write_cond = bus.PCWriteCond;
    v.iord          = bus.IorD;
    v.mem_read      = bus.MemRead;
    v.mem_write     = bus.MemWrite;
    v.ir_write      = bus.IRWrite;
    v.mem_to_reg    = bus.MemToReg;
    v.reg_dst       = bus.RegDst;
    v.reg_write     = bus.RegWrite;
    v.alu_src_a     = bus.ALUSrcA;
    v.alu_src_b     = bus.ALUSrcB;
    v.alu_op        = bus.ALUOp;
    v.pc_source     = bus.PCSource;
    v.illegal_op    = bus.IllegalOp;
    v.halted        = bus.Halted;
    return v;
  endfunction

  // What each step of an instruction must show on the outputs.
  function automatic ov_t expect_vec(int s, bit mr, logic [3:0] opc);
    ov_t v;
    v = '0;
    case (s)
      P_FETCH: begin
        v.mem_read = 1'b1; v.alu_src_b = 2'b01; v.ir_write = mr; v.pc_write = mr;
      end
      P_DECODE: begin
        v.alu_src_b  = 2'b11;
        v.illegal_op = !(opc <= 4'd5 || opc == 4'hF);
      end
      P_EXR:   begin v.alu_src_a = 1'b1; v.alu_op = 2'b10; end
      P_WBR:   begin v.reg_dst = 1'b1; v.reg_write = 1'b1; end
      P_EXI:   begin v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; end
      P_WBI:   begin v.reg_write = 1'b1; end
      P_MADDR: begin v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; end
      P_MRD:   begin v.mem_read = 1'b1; v.iord = 1'b1; end
      P_WBM:   begin v.mem_to_reg = 1'b1; v.reg_write = 1'b1; end
      P_MWR:   begin v.mem_write = 1'b1; v.iord = 1'b1; end
      P_BR: begin
        v.alu_src_a = 1'b1; v.alu_op = 2'b01; v.pc_write_cond = 1'b1; v.pc_source = 2'b01;
      end
      P_J:     begin v.pc_write = 1'b1; v.pc_source = 2'b10; end
      P_HALT:  begin v.halted = 1'b1; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    q.push_back(P_FETCH);
    m_count  = 0;
    retiring = 1'b0;
  endtask

  // Advance the model across one rising edge with Reset low.
  task automatic model_step(bit mr, logic [3:0] opc);
    int s;
    s = q[0];
    if ((s == P_FETCH || s == P_MRD || s == P_MWR) && !mr) return;
    if (s == P_HALT) return;
    void'(q.pop_front());
    if (s == P_FETCH) q.push_back(P_DECODE);
    if (s == P_DECODE) begin
      retiring = 1'b1;
      case (opc)
        4'h0: begin q.push_back(P_EXR); q.push_back(P_WBR); end
        4'h1: begin q.push_back(P_EXI); q.push_back(P_WBI); end
        4'h2: begin q.push_back(P_MADDR); q.push_back(P_MRD); q.push_back(P_WBM); end
        4'h3: begin q.push_back(P_MADDR); q.push_back(P_MWR); end
        4'h4: q.push_back(P_BR);
        4'h5: q.push_back(P_J);
        4'hF: begin q.push_back(P_HALT); retiring = 1'b0; end
        default: retiring = 1'b0;
      endcase
    end
    if (q.size() == 0) begin
      if (retiring) m_count = (m_count + 1) % (1 << CW);
      retiring  = 1'b0;
      instr_end = 1'b1;
      q.push_back(P_FETCH);
    end
  endtask

  // One clock: drive just after a rising edge, compare at the falling edge,
  // then let the model follow the next rising edge.
  task automatic cycle(bit r, bit mr, logic [3:0] opc, bit z);
    ov_t exp;
    rst          = r;
    bus.MemReady = mr;
    bus.Opcode   = opc;
    bus.Zero     = z;
    instr_end    = 1'b0;
    @(negedge clk);
    sv = dut_vec();
    sc = int'(bus.InstrCount);
    exp = r ? ov_t'('0) : expect_vec(q[0], mr, opc);
    chk_vec("outputs", sv, exp);
    chk("instr_count", sc, r ? 0 : int'(m_count));
    @(posedge clk);
    if (r) model_reset();
    else model_step(mr, opc);
    #1;
  endtask

  // Run one whole instruction from FETCH with random memory stalls.
  task automatic run_instr(logic [3:0] opc);
    int n;
    n = 0;
    do begin
      cycle(1'b0, $urandom_range(0, 3) != 0, opc, 1'($urandom_range(0, 1)));
      n++;
    end while (!instr_end && n < 40);
    if (!instr_end) chk("instr_bound", n, -1);
  endtask

  initial begin
    int hold, hcnt, mrcnt, k;
    logic [3:0] opc;
    bus.MemReady = 1'b0;
    bus.Opcode   = 4'h0;
    bus.Zero     = 1'b0;
    model_reset();

    // Reset for two cycles, then an R-type with MemReady high.
    cycle(1'b1, 1'b1, 4'h0, 1'b0);
    cycle(1'b1, 1'b1, 4'h0, 1'b0);
    chk_vec("reset_zero", sv, ov_t'('0));
    cycle(1'b0, 1'b1, 4'h0, 1'b0);
    chk("r_c1_aluop", int'(sv.alu_op), 0);
    chk("r_c1_irwrite", int'(sv.ir_write), 1);
    cycle(1'b0, 1'b1, 4'h0, 1'b0);
    chk("r_c2_aluop", int'(sv.alu_op), 0);
    chk("r_c2_alusrcb", int'(sv.alu_src_b), 3);
    cycle(1'b0, 1'b1, 4'h0, 1'b0);
    chk("r_c3_aluop", int'(sv.alu_op), 2);
    cycle(1'b0, 1'b1, 4'h0, 1'b0);
    chk("r_c4_regwrite", int'(sv.reg_write), 1);
    chk("r_c4_regdst", int'(sv.reg_dst), 1);
    chk("r_count", int'(bus.InstrCount), 1);

    // lw with three stalls in MEM_READ: 8 cycles in all.
    repeat (3) cycle(1'b0, 1'b1, 4'h2, 1'b0);
    hold = 0;
    repeat (3) begin
      cycle(1'b0, 1'b0, 4'h2, 1'b0);
      hold += int'(sv.mem_read & sv.iord);
    end
    cycle(1'b0, 1'b1, 4'h2, 1'b0);
    hold += int'(sv.mem_read & sv.iord);
    chk("lw_hold", hold, 4);
    cycle(1'b0, 1'b1, 4'h2, 1'b0);
    chk("lw_memtoreg", int'(sv.mem_to_reg), 1);
    chk("lw_count", int'(bus.InstrCount), 2);

    // beq with Zero high, then low: identical control, 3 cycles each.
    for (int zz = 1; zz >= 0; zz--) begin
      repeat (3) cycle(1'b0, 1'b1, 4'h4, 1'(zz));
      chk("beq_aluop", int'(sv.alu_op), 1);
      chk("beq_pcwcond", int'(sv.pc_write_cond), 1);
      chk("beq_pcsource", int'(sv.pc_source), 1);
    end
    chk("beq_count", int'(bus.InstrCount), 4);

    // Illegal opcode: one pulse in DECODE, back in FETCH, nothing retired.
    cycle(1'b0, 1'b1, 4'hA, 1'b0);
    chk("ill_fetch_pulse", int'(sv.illegal_op), 0);
    cycle(1'b0, 1'b1, 4'hA, 1'b0);
    chk("ill_pulse", int'(sv.illegal_op), 1);
    cycle(1'b0, 1'b0, 4'hA, 1'b0);
    chk("ill_after", int'(sv.illegal_op), 0);
    chk("ill_fetch", int'(sv.mem_read), 1);
    chk("ill_count", int'(bus.InstrCount), 4);

    // sw aborted by Reset while MEM_WRITE is stalled.
    cycle(1'b0, 1'b1, 4'h3, 1'b0);
    cycle(1'b0, 1'b1, 4'h3, 1'b0);
    cycle(1'b0, 1'b1, 4'h3, 1'b0);
    cycle(1'b0, 1'b0, 4'h3, 1'b0);
    chk("sw_memwrite", int'(sv.mem_write), 1);
    cycle(1'b1, 1'b0, 4'h3, 1'b0);
    chk_vec("sw_abort_zero", sv, ov_t'('0));
    cycle(1'b0, 1'b0, 4'h3, 1'b0);
    chk("sw_abort_fetch", int'(sv.mem_read), 1);
    chk("sw_abort_nowrite", int'(sv.mem_write), 0);

    // Halt: parked for 20 cycles whatever Opcode/MemReady do.
    cycle(1'b0, 1'b1, 4'hF, 1'b0);
    cycle(1'b0, 1'b1, 4'hF, 1'b0);
    hcnt = 0;
    mrcnt = 0;
    repeat (20) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);
      hcnt += int'(sv.halted);
      mrcnt += int'(sv.mem_read);
    end
    chk("halt_cycles", hcnt, 20);
    chk("halt_memread", mrcnt, 0);
    cycle(1'b1, 1'b0, 4'h0, 1'b0);
    cycle(1'b0, 1'b0, 4'h0, 1'b0);
    chk("halt_reset_fetch", int'(sv.mem_read), 1);
    chk("halt_reset_halted", int'(sv.halted), 0);
    chk("halt_reset_count", sc, 0);

    // Counter wrap via jumps.
    repeat ((1 << CW) - 1) run_instr(4'h5);
    chk("wrap_full", int'(bus.InstrCount), (1 << CW) - 1);
    run_instr(4'h5);
    chk("wrap_zero", int'(bus.InstrCount), 0);

    // Random traffic; Opcode changes every cycle, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 99);
      if (k < 85) opc = 4'($urandom_range(0, 5));
      else if (k < 97) opc = 4'($urandom_range(6, 14));
      else opc = 4'hF;
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, opc,
            1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
